rll_key_unit: RTL and testbench

Parametrised, clocked key-management and keyed-datapath block for random-logic-locked designs. It loads a KEY_W-bit key serially in CHUNK_W-bit beats over a valid/ready port and commits it atomically into a live key register. It then streams DATA_W-bit words through a bank of XOR/XNOR key gates into a one-stage registered valid/ready output. It generalises the fixed 32-input combinational key-gate netlists by adding width/polarity parameters, a load protocol, error handling and flow control.

---
 rtl/rll_pkg.sv | 18 +
 rtl/rll_key_gate_bank.sv | 19 +
 rtl/rll_key_unit.sv | 128 ++++++++++++
 tb/tb_rll_key_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_pkg.sv
// rtl/rll_pkg.sv - shared state type, lockout limit and bit-to-key index mapping for rll_key_unit
package rll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        ARMED   = 2'd2,
        LOCKOUT = 2'd3
    } rll_state_t;

    localparam int LOCKOUT_LIMIT = 3;

    // Data bits wrap around the key when DATA_W exceeds KEY_W.
    function automatic int key_index(input int bit_idx, input int key_w);
        return bit_idx % key_w;
    endfunction

endpackage

// File: rtl/rll_key_gate_bank.sv
// rtl/rll_key_gate_bank.sv - combinational XOR/XNOR key-gate array over a DATA_W-bit word
module rll_key_gate_bank
    import rll_pkg::*;
#(
    parameter int               KEY_W   = 32,
    parameter int               DATA_W  = 32,
    parameter logic [KEY_W-1:0] KEY_POL = '0
) (
    input  logic [KEY_W-1:0]  key,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] gated
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_gate
        localparam int J = key_index(i, KEY_W);
        assign gated[i] = data[i] ^ key[J] ^ KEY_POL[J];
    end

endmodule

// File: rtl/rll_key_unit.sv
// rtl/rll_key_unit.sv - serial key loader with atomic commit and registered keyed datapath
// Optional lockout after repeated malformed loads: define RLL_KEY_LOCKOUT_EN.
module rll_key_unit
    import rll_pkg::*;
#(
    parameter int               KEY_W   = 32,
    parameter int               CHUNK_W = 8,
    parameter int               DATA_W  = 32,
    parameter logic [KEY_W-1:0] KEY_POL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_vld,
    output logic               key_rdy,
    input  logic [CHUNK_W-1:0] key_data,
    input  logic               key_last,
    output logic               key_err,
    output logic               key_locked,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [DATA_W-1:0]  out_data
);

    localparam int NBEATS = KEY_W / CHUNK_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    rll_state_t         state;
    logic [KEY_W-1:0]   staging;
    logic [KEY_W-1:0]   staging_next;
    logic [KEY_W-1:0]   live_key;
    logic [CNT_W-1:0]   beat_cnt;
    logic [DATA_W-1:0]  gated;
    logic               beat_fire;
    logic               is_final;
    logic               load_err;
    logic               commit;
    int                 base;
`ifdef RLL_KEY_LOCKOUT_EN
    logic [1:0]         err_cnt;
`endif

    assign key_rdy   = (state != LOCKOUT);
    assign in_rdy    = key_locked && (!out_vld || out_rdy);
    assign beat_fire = key_vld && key_rdy;
    assign is_final  = (beat_cnt == LAST_BEAT);
    assign load_err  = beat_fire && (key_last != is_final);
    assign commit    = beat_fire && key_last && is_final;

    // The commit value must include the beat arriving on the commit edge.
    always_comb begin
        base         = int'(beat_cnt) * CHUNK_W;
        staging_next = staging;
        staging_next[base +: CHUNK_W] = key_data;
    end

    rll_key_gate_bank #(
        .KEY_W   (KEY_W),
        .DATA_W  (DATA_W),
        .KEY_POL (KEY_POL)
    ) u_gate_bank (
        .key   (live_key),
        .data  (in_data),
        .gated (gated)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            staging    <= '0;
            live_key   <= '0;
            beat_cnt   <= '0;
            key_err    <= 1'b0;
            key_locked <= 1'b0;
            out_vld    <= 1'b0;
            out_data   <= '0;
`ifdef RLL_KEY_LOCKOUT_EN
            err_cnt    <= 2'd0;
`endif
        end else begin
            key_err <= 1'b0;
            if (beat_fire) begin
                if (load_err) begin
                    key_err  <= 1'b1;
                    staging  <= '0;
                    beat_cnt <= '0;
`ifdef RLL_KEY_LOCKOUT_EN
                    if (err_cnt == 2'(LOCKOUT_LIMIT - 1)) begin
                        state      <= LOCKOUT;
                        live_key   <= '0;
                        key_locked <= 1'b0;
                    end else begin
                        err_cnt <= err_cnt + 2'd1;
                        state   <= key_locked ? ARMED : IDLE;
                    end
`else
                    state <= key_locked ? ARMED : IDLE;
`endif
                end else if (commit) begin
                    live_key   <= staging_next;
                    staging    <= '0;
                    beat_cnt   <= '0;
                    state      <= ARMED;
                    key_locked <= 1'b1;
`ifdef RLL_KEY_LOCKOUT_EN
                    err_cnt    <= 2'd0;
`endif
                end else begin
                    staging  <= staging_next;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    state    <= LOAD;
                end
            end

            // Words are gated with the key live at capture and never touched again.
            if (in_vld && in_rdy) begin
                out_data <= gated;
                out_vld  <= 1'b1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rll_key_unit.sv
// tb/tb_rll_key_unit.sv - scoreboard bench for rll_key_unit with directed key loads and data words
module tb_rll_key_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_vld;
    logic        key_rdy;
    logic [7:0]  key_data;
    logic        key_last;
    logic        key_err;
    logic        key_locked;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_data;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_data;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    rll_key_unit #(
        .KEY_W   (32),
        .CHUNK_W (8),
        .DATA_W  (32),
        .KEY_POL (32'hF0F0_F0F0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_vld    (key_vld),
        .key_rdy    (key_rdy),
        .key_data   (key_data),
        .key_last   (key_last),
        .key_err    (key_err),
        .key_locked (key_locked),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        key_vld  = 1'b1;
        key_data = d;
        key_last = last;
        step();
        key_vld  = 1'b0;
        key_last = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] k);
        for (int b = 0; b < 4; b++) beat(k[8*b +: 8], b == 3);
    endtask

    task automatic early_last_load();
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] e);
        int w;
        in_vld  = 1'b1;
        in_data = d;
        #1;
        w = 0;
        while (!in_rdy && w < 50) begin
            step();
            w++;
        end
        if (!in_rdy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_rdy got 0 expected 1 for word %h", d);
            in_vld = 1'b0;
        end else begin
            exp_q.push_back(e);
            step();
            in_vld = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (4) step();
    endtask

    // Monitor: every output transfer is matched against the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got %h expected no word", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_data", out_data, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        key_vld  = 1'b0;
        key_data = 8'h00;
        key_last = 1'b0;
        in_vld   = 1'b0;
        in_data  = 32'h0;
        out_rdy  = 1'b1;
        #12;
        chk("rst_key_locked", key_locked, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_key_rdy", key_rdy, 1);
        rst_n = 1'b1;
        step();

        // Early key_last with no key committed
        early_last_load();
        chk("early_err_pulse", key_err, 1);
        chk("early_locked", key_locked, 0);
        chk("early_in_rdy", in_rdy, 0);
        step();
        chk("early_err_clear", key_err, 0);

        // Correct key: gates become transparent
        load_key(32'hF0F0_F0F0);
        chk("commit_locked", key_locked, 1);
        send(32'h1234_5678, 32'h1234_5678);

        // Final beat without key_last: error, old key stays live
        for (int b = 0; b < 4; b++) beat(8'h5A, 1'b0);
        chk("nolast_err_pulse", key_err, 1);
        chk("nolast_locked", key_locked, 1);
        step();
        chk("nolast_err_clear", key_err, 0);
        send(32'h0000_0000, 32'h0000_0000);

        // Wrong key: one flipped bit, back-to-back words
        load_key(32'hF0F0_F0F1);
        send(32'h1234_5678, 32'h1234_5679);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        drain();

        // Backpressure
        out_rdy = 1'b0;
        send(32'h0000_0000, 32'h0000_0001);
        in_vld  = 1'b1;
        in_data = 32'hA5A5_A5A5;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_in_rdy", in_rdy, 0);
            chk("stall_out_data", out_data, 32'h0000_0001);
            step();
        end
        out_rdy = 1'b1;
        #1;
        chk("release_in_rdy", in_rdy, 1);
        exp_q.push_back(32'hA5A5_A5A4);
        step();
        in_vld = 1'b0;
        drain();

        // Rekey to 0F0F0F0F while streaming; commit-edge word keeps the old key
        for (int k = 0; k < 4; k++) begin
            key_vld  = 1'b1;
            key_data = 8'h0F;
            key_last = (k == 3);
            in_vld   = 1'b1;
            case (k)
                0: begin in_data = 32'h1111_1111; exp_q.push_back(32'h1111_1110); end
                1: begin in_data = 32'h2222_2222; exp_q.push_back(32'h2222_2223); end
                2: begin in_data = 32'h3333_3333; exp_q.push_back(32'h3333_3332); end
                default: begin in_data = 32'h4444_4444; exp_q.push_back(32'h4444_4445); end
            endcase
            step();
        end
        key_vld  = 1'b0;
        key_last = 1'b0;
        in_data  = 32'h5555_5555;
        exp_q.push_back(32'hAAAA_AAAA);
        step();
        in_vld = 1'b0;
        chk("rekey_locked", key_locked, 1);
        drain();

`ifdef RLL_KEY_LOCKOUT_EN
        for (int e = 0; e < 3; e++) begin
            early_last_load();
            chk("lock_err_pulse", key_err, 1);
        end
        chk("lockout_key_rdy", key_rdy, 0);
        chk("lockout_locked", key_locked, 0);
        chk("lockout_in_rdy", in_rdy, 0);
        step();
        chk("lockout_hold", key_rdy, 0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        chk("lockout_reset_key_rdy", key_rdy, 1);
`else
        for (int e = 0; e < 3; e++) begin
            early_last_load();
            chk("repeat_err_pulse", key_err, 1);
            chk("repeat_locked", key_locked, 1);
            chk("repeat_key_rdy", key_rdy, 1);
        end
        load_key(32'h0F0F_0F0F);
        chk("fourth_locked", key_locked, 1);
        send(32'h0000_0000, 32'hFFFF_FFFF);
        drain();
`endif

        // Asynchronous reset mid-load discards the partial key and beat count
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_locked", key_locked, 0);
        chk("midrst_out_vld", out_vld, 0);
        chk("midrst_in_rdy", in_rdy, 0);
        rst_n = 1'b1;
        step();
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b1);
        chk("midrst_err_pulse", key_err, 1);
        chk("midrst_no_commit", key_locked, 0);
        drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
